// File: rtl/oka_pipe_if.sv
// Handshake and data bundle for oka_pipe.
// Operand side: iValid/oReady with iX, iY, iTag.
// Product side: oValid/iReady with oO, oTag, plus the oBusy drain flag.
interface oka_pipe_if #(
  parameter int wI = 32,
  parameter int wT = 8
);

  logic            iValid;
  logic            oReady;
  logic [wI-1:0]   iX;
  logic [wI-1:0]   iY;
  logic [wT-1:0]   iTag;

  logic            oValid;
  logic            iReady;
  logic [2*wI-1:0] oO;
  logic [wT-1:0]   oTag;
  logic            oBusy;

  modport slave (
    input  iValid, iX, iY, iTag, iReady,
    output oReady, oValid, oO, oTag, oBusy
  );

  modport master (
    output iValid, iX, iY, iTag, iReady,
    input  oReady, oValid, oO, oTag, oBusy
  );

endinterface

// File: rtl/oka_pipe.sv
// Three-stage pipelined Karatsuba multiplier with valid/ready handshakes
// on both sides and a sideband tag that travels with each product.
// Stage 1 splits the operands and forms the half sums, stage 2 forms the
// three partial products, stage 3 recombines them into the output register.
// Each stage advances whenever the stage after it can make room, so idle
// slots collapse and a full pipe still streams one result per cycle.
module oka_pipe #(
  parameter int wI = 32,
  parameter int wO = 2 * wI,
  parameter int wT = 8
) (
  input  logic      iClk,
  input  logic      iRst_n,
  oka_pipe_if.slave bus
);

  localparam int H = wI / 2;

  logic           rdy1;
  logic           rdy2;
  logic           rdy3;

  logic           v1_q;
  logic [H-1:0]   xl1_q;
  logic [H-1:0]   xh1_q;
  logic [H-1:0]   yl1_q;
  logic [H-1:0]   yh1_q;
  logic [H:0]     sx1_q;
  logic [H:0]     sy1_q;
  logic [wT-1:0]  tag1_q;

  logic           v2_q;
  logic [2*H-1:0] p0_q;
  logic [2*H-1:0] p2_q;
  logic [2*H+1:0] pm_q;
  logic [wT-1:0]  tag2_q;

  logic           v3_q;
  logic [wO-1:0]  o_q;
  logic [wT-1:0]  tag3_q;

  logic [H:0]     sx_d;
  logic [H:0]     sy_d;
  logic [2*H-1:0] p0_d;
  logic [2*H-1:0] p2_d;
  logic [2*H+1:0] pm_d;
  logic [2*H+1:0] p1Full;
  logic [wO-1:0]  o_d;

  // Ready ripples back from the output: a stage can load if it is empty or its successor can load
  always_comb begin
    rdy3 = !v3_q || bus.iReady;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;
  end

  // Half sums of the operand halves; the extra top bit keeps the carry
  always_comb begin
    sx_d = {1'b0, bus.iX[wI-1:H]} + {1'b0, bus.iX[H-1:0]};
    sy_d = {1'b0, bus.iY[wI-1:H]} + {1'b0, bus.iY[H-1:0]};
  end

  // Stage 1: capture the split operands, half sums and tag on an accepted input
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      v1_q   <= 1'b0;
      xl1_q  <= '0;
      xh1_q  <= '0;
      yl1_q  <= '0;
      yh1_q  <= '0;
      sx1_q  <= '0;
      sy1_q  <= '0;
      tag1_q <= '0;
    end else if (rdy1) begin
      v1_q <= bus.iValid;
      if (bus.iValid) begin
        xl1_q  <= bus.iX[H-1:0];
        xh1_q  <= bus.iX[wI-1:H];
        yl1_q  <= bus.iY[H-1:0];
        yh1_q  <= bus.iY[wI-1:H];
        sx1_q  <= sx_d;
        sy1_q  <= sy_d;
        tag1_q <= bus.iTag;
      end
    end
  end

  // The three half-width partial products; operands are widened so nothing truncates
  always_comb begin
    p0_d = {{H{1'b0}}, xl1_q} * {{H{1'b0}}, yl1_q};
    p2_d = {{H{1'b0}}, xh1_q} * {{H{1'b0}}, yh1_q};
    pm_d = {{(H+1){1'b0}}, sx1_q} * {{(H+1){1'b0}}, sy1_q};
  end

  // Stage 2: register the partial products and tag as stage 1 drains forward
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      v2_q   <= 1'b0;
      p0_q   <= '0;
      p2_q   <= '0;
      pm_q   <= '0;
      tag2_q <= '0;
    end else if (rdy2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        p0_q   <= p0_d;
        p2_q   <= p2_d;
        pm_q   <= pm_d;
        tag2_q <= tag1_q;
      end
    end
  end

  // Middle term and recombination; P0 never reaches bit wI so P2 and P0 simply concatenate
  always_comb begin
    p1Full = pm_q - {2'b00, p0_q} - {2'b00, p2_q};
    o_d    = {p2_q, p0_q} + (wO'(p1Full) << H);
  end

  // Stage 3: output register, held steady while the consumer stalls
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      v3_q   <= 1'b0;
      o_q    <= '0;
      tag3_q <= '0;
    end else if (rdy3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        o_q    <= o_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign bus.oReady = rdy1;
  assign bus.oValid = v3_q;
  assign bus.oO     = o_q;
  assign bus.oTag   = tag3_q;
  assign bus.oBusy  = v1_q | v2_q | v3_q;

endmodule

// File: doc/oka_pipe.md
Name: oka_pipe

Overview:
- Pipelined, parametrised Karatsuba multiplier. Produces the exact unsigned product of two wI-bit operands.
- Successor to the team's combinational Karatsuba block. Adds a 3-stage register pipeline, valid/ready handshakes on both sides with per-stage bubble collapse, and a sideband tag carried with each product.
- Sits in the NTT butterfly datapath ahead of modular reduction. The tag lets the butterfly controller match each product to its coefficient index.

Parameters:
- wI, 32, operand width in bits. Must be even and ≥ 4.
- wO, 2*wI, product width in bits. Fixed relation; any other value is illegal.
- wT, 8, tag width in bits. Must be ≥ 1.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iValid  input  1  operand pair and tag valid this cycle.
- oReady  output  1  block accepts an input this cycle.
- iX  input  wI  multiplicand, unsigned.
- iY  input  wI  multiplier, unsigned.
- iTag  input  wT  sideband tag, passed through unmodified.
- oValid  output  1  oO/oTag valid this cycle.
- iReady  input  1  downstream accepts the output this cycle.
- oO  output  wO  product iX*iY.
- oTag  output  wT  tag that entered with this product.
- oBusy  output  1  OR of all stage valid bits.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - All stage valid bits to 0.
  - oValid=0, oBusy=0, oO=0, oTag=0.
  - Data registers of stages 1 and 2 to 0.
- Reset asserted mid-operation discards every in-flight transaction. No output is produced for them after release.
- Split (h=wI/2): Xl=iX[h-1:0], Xh=iX[wI-1:h]; Yl and Yh likewise.
- Stage 1 registers, with the tag:
  - Xl, Xh, Yl, Yh.
  - Sx=Xh+Xl and Sy=Yh+Yl, each h+1 bits. The carry must be kept.
- Stage 2 registers, with the tag:
  - P0=Xl*Yl and P2=Xh*Yh, each 2h bits.
  - Pm=Sx*Sy, 2h+2 bits.
- Stage 3 (output register):
  - P1=Pm-P0-P2, which is non-negative and fits in 2h+1 bits.
  - oO = (P2<<wI) + (P1<<h) + P0, truncated to wO bits. No overflow is possible.
  - oTag registered alongside oO.
- Handshake:
  - An input transfer occurs when iValid && oReady.
  - An output transfer occurs when oValid && iReady.
- Stage advance rule, with stage 3 valid = oValid:
  - rdy3 = !oValid || iReady
  - rdy2 = !v2 || rdy3
  - rdy1 = !v1 || rdy2
  - oReady = rdy1
  - Combinational ready path; no register on it.
- Stage k loads from stage k-1 when rdy_k is 1. Its valid bit then becomes the upstream valid bit, so bubbles are overwritten and collapse.
- While rdy_k=0, stage k holds its data and valid bit unchanged.
- Latency: 3 cycles from input transfer to oValid, when unstalled.
- Throughput: 1 transaction per cycle when iReady is held at 1.
- Capacity: 3 transactions. With iReady=0 and all stages full, oReady=0.
- Simultaneous output transfer and full pipe:
  - oReady=1 in the same cycle.
  - The pipe shifts, accepting a new input and emitting one result in that cycle.
- Output stability: while oValid && !iReady, oO and oTag must not change.
- Ordering: strictly in-order. The tag is never reordered relative to its product.
- Data registers are updated only on stage load. Their values while the stage is invalid are don't-care, but must not cause X propagation after reset.
- oBusy = v1 | v2 | oValid. It is used by the controller for drain detection.

Test Plan:
- Reset then idle:
  - Release iRst_n with iValid=0 → oValid=0, oO=0, oBusy=0, oReady=1.
  - Assert iRst_n low asynchronously mid-stream → outputs clear immediately, with no clock edge needed.
- Basic latency (wI=32, iReady=1):
  - Drive iX=0xFFFFFFFF, iY=0xFFFFFFFF, iTag=0x5A at cycle 0.
  - Expect oValid=1 at cycle 3 with oO=0xFFFFFFFE00000001 and oTag=0x5A.
- Karatsuba carry paths:
  - 0xFFFF0000*0x0000FFFF → 0x0000FFFE00010000.
  - 0x80000000*0x00000002 → 0x0000000100000000.
  - 0x00010000*0x00010000 → 0x0000000100000000.
  - 0*0xFFFFFFFF → 0.
- Back-pressure:
  - Stream 5 transactions with iReady=0.
  - Expect oReady to drop after 3 accepts, oO/oTag stable while held, and oBusy=1.
  - Raise iReady → the 5 results emerge in order with correct tags, 1 per cycle.
- Bubble collapse:
  - Send 1 input, stall the output with iReady=0, then send 2 more inputs spaced by idle cycles.
  - Expect all 3 to be resident (oReady=0) before iReady returns.
  - Ordering must be preserved.
- Random regression:
  - Run 10k random operands, random iValid/iReady, and wI in {16, 32, 64}.
  - Scoreboard checks oO against iX*iY and oTag against iTag.
  - Throughput must be 1/cycle whenever iValid=iReady=1.
